// File: rtl/bin2bcd4_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD
// converter (double dabble) that feeds the 4-digit 7-segment driver.
package bin2bcd4_seq_pkg;
   localparam int BCD_W  = 4;     // bits per BCD digit
   localparam int NDIG   = 4;     // number of output digits
   localparam int MAXVAL = 9999;  // largest value representable in NDIG digits

   // 2'd3 is unused and decodes back to IDLE in the FSM.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;
endpackage

// File: rtl/bin2bcd4_seq_if.sv
// Request/result bundle of bin2bcd4_seq.
//   start  : conversion request (producer -> converter)
//   bin    : unsigned value to convert, WIDTH bits
//   busy   : conversion in progress
//   done   : one-cycle pulse, digits just updated
//   ovf    : last committed input exceeded MAXVAL
//   dig0-3 : units, tens, hundreds, thousands (BCD)
interface bin2bcd4_seq_if import bin2bcd4_seq_pkg::*; #(
   parameter int WIDTH = 14
) ();
   logic             start;
   logic [WIDTH-1:0] bin;
   logic             busy;
   logic             done;
   logic             ovf;
   logic [BCD_W-1:0] dig0;
   logic [BCD_W-1:0] dig1;
   logic [BCD_W-1:0] dig2;
   logic [BCD_W-1:0] dig3;

   modport master (output start, bin,
                   input  busy, done, ovf, dig0, dig1, dig2, dig3);
   modport slave  (input  start, bin,
                   output busy, done, ovf, dig0, dig1, dig2, dig3);
endinterface

// File: rtl/bin2bcd4_seq_add3.sv
// Double-dabble nibble corrector: adds 3 to a BCD digit >= 5 so that the
// following left shift carries correctly into the next digit.
//   din  : work-register nibble
//   dout : corrected nibble (max 4'd12, never wraps)
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd4_seq.sv
// Sequential binary-to-BCD converter. One iteration per clock: correct all
// work nibbles, then shift {bcd, shift} left by one. Results are committed
// to the digit registers only at the end, so the display never sees
// intermediate values.
//   ck  : clock, rising edge
//   R   : asynchronous active-low reset
//   bus : slave side of bin2bcd4_seq_if (start/bin in, busy/done/ovf/dig out)
module bin2bcd4_seq import bin2bcd4_seq_pkg::*; #(
   parameter int WIDTH = 14
) (
   input logic           ck,
   input logic           R,
   bin2bcd4_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = BCD_W * NDIG;

   state_t                        state_q, state_d;
   logic [WIDTH-1:0]              shift_q;
   logic [BW-1:0]                 bcd_q, bcd_adj;
   logic [CW-1:0]                 cnt_q;
   logic                          ovf_n_q, ovf_q, done_q;
   logic [NDIG-1:0][BCD_W-1:0]    dig_q;
   logic                          over, last;
   logic [WIDTH-1:0]              bin_sat;

   // Clamp in 32-bit space so narrow WIDTH values compare correctly.
   assign over    = 32'(bus.bin) > MAXVAL;
   assign bin_sat = over ? WIDTH'(MAXVAL) : bus.bin;
   assign last    = (cnt_q == CW'(WIDTH - 1));

   for (genvar g = 0; g < NDIG; g++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (bcd_q[g*BCD_W +: BCD_W]),
         .dout (bcd_adj[g*BCD_W +: BCD_W])
      );
   end

   always_ff @(posedge ck or negedge R) begin
      if (!R) state_q <= ST_IDLE;
      else    state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
         ST_SHIFT: if (last)      state_d = ST_DONE;
         ST_DONE:                 state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ck or negedge R) begin
      if (!R) begin
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ovf_n_q <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         dig_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (bus.start) begin
               shift_q <= bin_sat;
               ovf_n_q <= over;
               bcd_q   <= '0;
               cnt_q   <= '0;
            end
            ST_SHIFT: begin
               // Corrected BCD and binary shift as one wide register.
               {bcd_q, shift_q} <= {bcd_adj[BW-2:0], shift_q, 1'b0};
               cnt_q            <= cnt_q + CW'(1);
            end
            ST_DONE: begin
               dig_q  <= bcd_q;
               ovf_q  <= ovf_n_q;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // busy covers SHIFT and DONE; done is registered and rises as busy falls.
   assign bus.busy = (state_q == ST_SHIFT) || (state_q == ST_DONE);
   assign bus.done = done_q;
   assign bus.ovf  = ovf_q;
   assign bus.dig0 = dig_q[0];
   assign bus.dig1 = dig_q[1];
   assign bus.dig2 = dig_q[2];
   assign bus.dig3 = dig_q[3];
endmodule

// File: tb/tb_bin2bcd4_seq.sv
// Self-checking bench for bin2bcd4_seq: directed cases plus random values,
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd4_seq;
   import bin2bcd4_seq_pkg::*;
   localparam int WIDTH = 14;

   logic ck = 1'b0;
   logic R  = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cur_bcd = 0;   // digits the DUT should be holding
   int   cur_ovf = 0;

   bin2bcd4_seq_if #(.WIDTH(WIDTH)) bus ();
   bin2bcd4_seq #(.WIDTH(WIDTH)) dut (.ck(ck), .R(R), .bus(bus));

   always #5 ck = ~ck;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference: clamp, then split into decimal digits packed one per nibble.
   function automatic int ref_bcd(input int v);
      int c;
      c = (v > MAXVAL) ? MAXVAL : v;
      return (((c / 1000) % 10) << 12) | (((c / 100) % 10) << 8) |
             (((c / 10) % 10) << 4) | (c % 10);
   endfunction

   function automatic int obs_bcd();
      return int'({bus.dig3, bus.dig2, bus.dig1, bus.dig0});
   endfunction

   // One conversion of v. glitch_k>0: extra start (bin=777) sampled at edge
   // t(glitch_k). rst_k>0: reset dropped just before edge t(rst_k).
   task automatic convert(input int v, input int glitch_k, input int rst_k,
                          input string tag);
      int lat = 0, busy_n = 0, both = 0, hold_bad = 0, extra = 0;
      @(negedge ck);
      bus.start = 1'b1;
      bus.bin   = WIDTH'(v);
      @(posedge ck); #1;
      bus.start = 1'b0;
      bus.bin   = WIDTH'($urandom);
      for (int k = 0; k <= 40; k++) begin
         if (k > 0) begin @(posedge ck); #1; end
         if (bus.done && bus.busy) both++;
         if (bus.done) begin lat = k; break; end
         if (bus.busy) busy_n++;
         if (obs_bcd() != cur_bcd || int'(bus.ovf) != cur_ovf) hold_bad++;
         if (glitch_k > 0 && k == glitch_k - 1) begin bus.start = 1'b1; bus.bin = WIDTH'(777); end
         if (glitch_k > 0 && k == glitch_k) bus.start = 1'b0;
         if (rst_k > 0 && k == rst_k - 1) begin
            #2 R = 1'b0;
            #1;
            chk({tag, "_rst_dig"},  obs_bcd(),      0);
            chk({tag, "_rst_ovf"},  int'(bus.ovf),  0);
            chk({tag, "_rst_busy"}, int'(bus.busy), 0);
            chk({tag, "_rst_done"}, int'(bus.done), 0);
            cur_bcd = 0;
            cur_ovf = 0;
            repeat (20) begin
               @(posedge ck); #1;
               if (bus.done) extra++;
            end
            chk({tag, "_rst_nodone"}, extra, 0);
            @(negedge ck);
            R = 1'b1;
            return;
         end
      end
      chk({tag, "_lat"},  lat,    15);
      chk({tag, "_busy"}, busy_n, 15);
      chk({tag, "_dig"},  obs_bcd(), ref_bcd(v));
      chk({tag, "_ovf"},  int'(bus.ovf), (v > MAXVAL) ? 1 : 0);
      cur_bcd = ref_bcd(v);
      cur_ovf = (v > MAXVAL) ? 1 : 0;
      // Idle window: no further done, digits held.
      repeat (20) begin
         @(posedge ck); #1;
         if (bus.done) extra++;
         if (bus.done && bus.busy) both++;
         if (obs_bcd() != cur_bcd || int'(bus.ovf) != cur_ovf) hold_bad++;
      end
      chk({tag, "_single"}, extra,    0);
      chk({tag, "_excl"},   both,     0);
      chk({tag, "_hold"},   hold_bad, 0);
   endtask

   initial begin
      int idx, since, hold_bad, both;
      bus.start = 1'b0;
      bus.bin   = '0;
      #1;
      chk("reset_dig",  obs_bcd(),      0);
      chk("reset_ovf",  int'(bus.ovf),  0);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_done", int'(bus.done), 0);
      repeat (2) @(negedge ck);
      R = 1'b1;

      convert(0,     0, 0, "t1_zero");
      convert(1234,  0, 0, "t2_1234");
      convert(9999,  0, 0, "t3_max");
      convert(10000, 0, 0, "t3_clamp");
      convert(5,     0, 0, "t3_five");
      convert(42,    5, 0, "t4_ignore");
      convert(1234,  0, 0, "t5_pre");
      convert(8765,  0, 7, "t5_abort");
      convert(31,    0, 0, "t5_after");
      repeat (8) convert(int'($urandom_range(0, 16383)), 0, 0, "rnd");

      // Back-to-back: start held high, new bin applied after each done.
      idx = 0; since = 0; hold_bad = 0; both = 0;
      @(negedge ck);
      bus.bin   = WIDTH'(0);
      bus.start = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge ck); #1;
         since++;
         if (bus.done && bus.busy) both++;
         if (bus.done) begin
            chk("t6_dig",  obs_bcd(), ref_bcd(idx * 1111));
            chk("t6_ovf",  int'(bus.ovf), 0);
            chk("t6_gap",  since, 16);
            chk("t6_hold", hold_bad, 0);
            cur_bcd  = ref_bcd(idx * 1111);
            cur_ovf  = 0;
            since    = 0;
            hold_bad = 0;
            idx++;
            if (idx == 10) begin bus.start = 1'b0; break; end
            bus.bin = WIDTH'(idx * 1111);
         end else if (obs_bcd() != cur_bcd || int'(bus.ovf) != cur_ovf) begin
            hold_bad++;
         end
      end
      bus.start = 1'b0;
      chk("t6_count", idx,  10);
      chk("t6_excl",  both, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
